// File: rtl/alu_pkg.sv
// Shared widths, ALU opcodes and FSM encoding for the ALU request arbiter.
package alu_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int RES_W_DEF  = 16;
   localparam int CMD_W_DEF  = 4;

   typedef enum logic [3:0] {
      CMD_ADD = 4'b0000,
      CMD_SUB = 4'b0001,
      CMD_MUL = 4'b0010,
      CMD_INC = 4'b0011,
      CMD_DEC = 4'b0100,
      CMD_DIV = 4'b0101,
      CMD_MOD = 4'b0110,
      CMD_AND = 4'b0111,
      CMD_OR  = 4'b1000,
      CMD_XOR = 4'b1001,
      CMD_NOT = 4'b1010,
      CMD_SHL = 4'b1011,
      CMD_SHR = 4'b1100,
      CMD_CMP = 4'b1101,
      CMD_PSA = 4'b1110,
      CMD_BUF = 4'b1111
   } alu_cmd_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      RESP  = 2'b10
   } arb_state_e;

   // True when a command/operand pair would divide by zero.
   function automatic logic is_div_by_zero(input logic [CMD_W_DEF-1:0] cmd,
                                           input logic [DATA_W_DEF-1:0] b);
      return (cmd == CMD_DIV) && (b == {DATA_W_DEF{1'b0}});
   endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Request, response and ALU pin bundle of the arbiter; slave = arbiter side.
interface alu_req_arbiter_if
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RES_W  = RES_W_DEF,
   parameter int CMD_W  = CMD_W_DEF
) ();

   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [CMD_W-1:0]  req0_cmd;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic [CMD_W-1:0]  req1_cmd;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic              resp_valid;
   logic              resp_ready;
   logic              resp_id;
   logic [RES_W-1:0]  resp_data;
   logic              resp_err;
   logic [DATA_W-1:0] alu_a_out;
   logic [DATA_W-1:0] alu_b_out;
   logic [CMD_W-1:0]  alu_cmd_out;
   logic              alu_oe_out;
   logic [RES_W-1:0]  alu_d_in;

   modport slave (
      input  req_valid, req0_cmd, req0_a, req0_b, req1_cmd, req1_a, req1_b,
      input  resp_ready, alu_d_in,
      output req_ready, resp_valid, resp_id, resp_data, resp_err,
      output alu_a_out, alu_b_out, alu_cmd_out, alu_oe_out
   );

   modport master (
      output req_valid, req0_cmd, req0_a, req0_b, req1_cmd, req1_a, req1_b,
      output resp_ready, alu_d_in,
      input  req_ready, resp_valid, resp_id, resp_data, resp_err,
      input  alu_a_out, alu_b_out, alu_cmd_out, alu_oe_out
   );

endinterface

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant; rr_ptr names the preferred requester.
module rr_arb2 (
   input  logic [1:0] req_valid,
   input  logic       rr_ptr,
   output logic [1:0] grant,
   output logic       any_grant
);

   // One-hot grant: a lone requester always wins, a tie goes to rr_ptr.
   always_comb begin
      grant = 2'b00;
      case (req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   assign any_grant = |req_valid;

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one combinational ALU between two requesters, one operation in flight.
// Optional ALU_DIV0_CHECK_EN: answer DIV-by-zero with resp_err instead of issuing it.
module alu_req_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RES_W  = RES_W_DEF,
   parameter int CMD_W  = CMD_W_DEF
) (
   input  logic               clock,
   input  logic               resetn,
   alu_req_arbiter_if.slave   bus
);

   arb_state_e        state_q, state_d;
   logic              rr_ptr_q, rr_ptr_d;
   logic              id_q, id_d;
   logic [CMD_W-1:0]  cmd_q, cmd_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [RES_W-1:0]  resp_data_q, resp_data_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_err_q, resp_err_d;

   logic [1:0]        grant_s;
   logic              any_grant_s;
   logic [1:0]        req_ready_s;
   logic              win_id_s;
   logic [CMD_W-1:0]  win_cmd_s;
   logic [DATA_W-1:0] win_a_s;
   logic [DATA_W-1:0] win_b_s;

   rr_arb2 u_arb (
      .req_valid (bus.req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant     (grant_s),
      .any_grant (any_grant_s)
   );

   assign win_id_s  = grant_s[1];
   assign win_cmd_s = win_id_s ? bus.req1_cmd : bus.req0_cmd;
   assign win_a_s   = win_id_s ? bus.req1_a   : bus.req0_a;
   assign win_b_s   = win_id_s ? bus.req1_b   : bus.req0_b;

   // Next-state, operand latching and response capture.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      id_d         = id_q;
      cmd_d        = cmd_q;
      a_d          = a_q;
      b_d          = b_q;
      resp_data_d  = resp_data_q;
      resp_valid_d = resp_valid_q;
      resp_err_d   = resp_err_q;
      req_ready_s  = 2'b00;
      case (state_q)
         IDLE: begin
            // Grant only lands on a valid requester, so ready implies the handshake.
            if (any_grant_s) begin
               req_ready_s = grant_s;
               rr_ptr_d    = ~win_id_s;
               id_d        = win_id_s;
               cmd_d       = win_cmd_s;
               a_d         = win_a_s;
               b_d         = win_b_s;
               resp_err_d  = 1'b0;
               state_d     = ISSUE;
`ifdef ALU_DIV0_CHECK_EN
               if (is_div_by_zero(win_cmd_s, win_b_s)) begin
                  resp_data_d  = {RES_W{1'b0}};
                  resp_err_d   = 1'b1;
                  resp_valid_d = 1'b1;
                  state_d      = RESP;
               end else begin
                  state_d = ISSUE;
               end
`endif
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            resp_data_d  = bus.alu_d_in;
            resp_valid_d = 1'b1;
            state_d      = RESP;
         end
         RESP: begin
            if (bus.resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            resp_valid_d = 1'b0;
            state_d      = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         rr_ptr_q     <= 1'b0;
         id_q         <= 1'b0;
         cmd_q        <= {CMD_W{1'b0}};
         a_q          <= {DATA_W{1'b0}};
         b_q          <= {DATA_W{1'b0}};
         resp_data_q  <= {RES_W{1'b0}};
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         id_q         <= id_d;
         cmd_q        <= cmd_d;
         a_q          <= a_d;
         b_q          <= b_d;
         resp_data_q  <= resp_data_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign bus.req_ready   = req_ready_s;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_id     = id_q;
   assign bus.resp_data   = resp_data_q;
   assign bus.resp_err    = resp_err_q;
   assign bus.alu_a_out   = a_q;
   assign bus.alu_b_out   = b_q;
   assign bus.alu_cmd_out = cmd_q;
   assign bus.alu_oe_out  = (state_q == ISSUE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed and randomized bench for alu_req_arbiter with a behavioural ALU and arbiter model.
module tb_alu_req_arbiter;
   import alu_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   alu_req_arbiter_if bus ();

   alu_req_arbiter dut (
      .clock  (clk),
      .resetn (rst_n),
      .bus    (bus)
   );

   // Behavioural ALU; the bus carries junk whenever the ALU is not enabled.
   function automatic logic [15:0] alu_f(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] xa;
      logic [15:0] xb;
      xa = {8'h00, a};
      xb = {8'h00, b};
      case (cmd)
         4'h0:    return xa + xb;
         4'h1:    return xa - xb;
         4'h2:    return xa * xb;
         4'h3:    return xa + 16'd1;
         4'h4:    return xa - 16'd1;
         4'h5:    return (b == 8'h00) ? 16'hFFFF : xa / xb;
         4'h6:    return (b == 8'h00) ? xa : xa % xb;
         4'h7:    return xa & xb;
         4'h8:    return xa | xb;
         4'h9:    return xa ^ xb;
         4'hA:    return {8'h00, ~a};
         4'hB:    return xa << 1;
         4'hC:    return xa >> 1;
         4'hD:    return {15'd0, (a < b)};
         4'hE:    return xa;
         default: return xb;
      endcase
   endfunction

   assign bus.alu_d_in = bus.alu_oe_out ? alu_f(bus.alu_cmd_out, bus.alu_a_out, bus.alu_b_out) : 16'hBEEF;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.req_valid = 2'b00; bus.resp_ready = 1'b0;
      bus.req0_cmd = 4'h0; bus.req0_a = 8'h00; bus.req0_b = 8'h00;
      bus.req1_cmd = 4'h0; bus.req1_a = 8'h00; bus.req1_b = 8'h00;
      repeat (2) step();
      n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
      n_checks++; if (bus.alu_oe_out !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", bus.alu_oe_out); end
      n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); end
      n_checks++; if ({bus.resp_id, bus.resp_err} !== 2'b00) begin n_fail++; $display("FAIL reset_id_err: got %b want 00", {bus.resp_id, bus.resp_err}); end
      n_checks++; if (bus.resp_data !== 16'h0000) begin n_fail++; $display("FAIL reset_resp_data: got %h want 0000", bus.resp_data); end
      n_checks++; if ({bus.alu_cmd_out, bus.alu_a_out, bus.alu_b_out} !== 20'h00000) begin n_fail++; $display("FAIL reset_alu_pins: got %h want 00000", {bus.alu_cmd_out, bus.alu_a_out, bus.alu_b_out}); end
      rst_n = 1'b1;
   endtask

   task automatic test_contention();
      logic exp_id;
      bus.req0_cmd = 4'h2; bus.req0_a = 8'd15; bus.req0_b = 8'd17;
      bus.req1_cmd = 4'h1; bus.req1_a = 8'd10; bus.req1_b = 8'd3;
      bus.resp_ready = 1'b1;
      bus.req_valid  = 2'b11;
      #1;
      for (int k = 0; k < 4; k++) begin
         exp_id = k[0];
         n_checks++; if (bus.req_ready !== (exp_id ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL contention_grant%0d: got %b want id %0d", k, bus.req_ready, exp_id); end
         step();
         n_checks++; if (bus.alu_oe_out !== 1'b1) begin n_fail++; $display("FAIL contention_oe%0d: got %b want 1", k, bus.alu_oe_out); end
         step();
         n_checks++; if ({bus.resp_valid, bus.resp_id} !== {1'b1, exp_id}) begin n_fail++; $display("FAIL contention_resp%0d: got valid/id %b want 1%b", k, {bus.resp_valid, bus.resp_id}, exp_id); end
         n_checks++; if (bus.resp_data !== (exp_id ? 16'd7 : 16'd255)) begin n_fail++; $display("FAIL contention_data%0d: got %0d want %0d", k, bus.resp_data, exp_id ? 7 : 255); end
         step();
      end
      bus.req_valid = 2'b00;
   endtask

   task automatic test_single_op();
      bus.req0_cmd = 4'h0; bus.req0_a = 8'd20; bus.req0_b = 8'd22;
      bus.resp_ready = 1'b1;
      bus.req_valid  = 2'b01;
      #1;
      n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b want 01", bus.req_ready); end
      step();
      bus.req_valid = 2'b00; bus.req0_a = 8'd99;
      n_checks++; if ({bus.alu_oe_out, bus.resp_valid} !== 2'b10) begin n_fail++; $display("FAIL single_issue: got oe/valid %b want 10", {bus.alu_oe_out, bus.resp_valid}); end
      step();
      n_checks++; if ({bus.alu_oe_out, bus.resp_valid, bus.resp_id} !== 3'b010) begin n_fail++; $display("FAIL single_resp: got oe/valid/id %b want 010", {bus.alu_oe_out, bus.resp_valid, bus.resp_id}); end
      n_checks++; if (bus.resp_data !== 16'd42) begin n_fail++; $display("FAIL single_data: got %0d want 42", bus.resp_data); end
      step();
      n_checks++; if ({bus.alu_oe_out, bus.resp_valid} !== 2'b00) begin n_fail++; $display("FAIL single_done: got oe/valid %b want 00", {bus.alu_oe_out, bus.resp_valid}); end
   endtask

   task automatic test_backpressure();
      bus.req0_cmd = 4'h0; bus.req0_a = 8'd1;    bus.req0_b = 8'd1;
      bus.req1_cmd = 4'h9; bus.req1_a = 8'hA5;   bus.req1_b = 8'h0F;
      bus.resp_ready = 1'b0;
      bus.req_valid  = 2'b11;
      #1;
      n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_grant: got %b want 10", bus.req_ready); end
      step();
      step();
      for (int k = 0; k < 5; k++) begin
         n_checks++; if ({bus.resp_valid, bus.resp_id, bus.resp_data, bus.req_ready} !== {1'b1, 1'b1, 16'h00AA, 2'b00}) begin
            n_fail++; $display("FAIL bp_hold%0d: got valid %b id %b data %h ready %b want 1 1 00aa 00", k, bus.resp_valid, bus.resp_id, bus.resp_data, bus.req_ready);
         end
         step();
      end
      bus.resp_ready = 1'b1;
      step();
      n_checks++; if ({bus.resp_valid, bus.req_ready} !== 3'b001) begin n_fail++; $display("FAIL bp_release: got valid/ready %b want 001", {bus.resp_valid, bus.req_ready}); end
      bus.req_valid = 2'b00;
   endtask

   task automatic test_div0();
      bus.req1_cmd = 4'h5; bus.req1_a = 8'd9; bus.req1_b = 8'd0;
      bus.resp_ready = 1'b1;
      bus.req_valid  = 2'b10;
      #1;
      n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL div0_ready: got %b want 10", bus.req_ready); end
      step();
      bus.req_valid = 2'b00;
`ifdef ALU_DIV0_CHECK_EN
      n_checks++; if ({bus.alu_oe_out, bus.resp_valid, bus.resp_err, bus.resp_id} !== 4'b0111) begin n_fail++; $display("FAIL div0_resp: got oe/valid/err/id %b want 0111", {bus.alu_oe_out, bus.resp_valid, bus.resp_err, bus.resp_id}); end
      n_checks++; if (bus.resp_data !== 16'h0000) begin n_fail++; $display("FAIL div0_data: got %h want 0000", bus.resp_data); end
      step();
      n_checks++; if ({bus.alu_oe_out, bus.resp_valid} !== 2'b00) begin n_fail++; $display("FAIL div0_done: got oe/valid %b want 00", {bus.alu_oe_out, bus.resp_valid}); end
`else
      n_checks++; if ({bus.alu_oe_out, bus.resp_valid} !== 2'b10) begin n_fail++; $display("FAIL div0_issue: got oe/valid %b want 10", {bus.alu_oe_out, bus.resp_valid}); end
      step();
      n_checks++; if ({bus.resp_valid, bus.resp_err, bus.resp_id} !== 3'b101) begin n_fail++; $display("FAIL div0_resp: got valid/err/id %b want 101", {bus.resp_valid, bus.resp_err, bus.resp_id}); end
      n_checks++; if (bus.resp_data !== 16'hFFFF) begin n_fail++; $display("FAIL div0_data: got %h want ffff", bus.resp_data); end
      step();
`endif
   endtask

   task automatic test_reset_mid_op();
      bus.req0_cmd = 4'h0; bus.req0_a = 8'd1; bus.req0_b = 8'd2;
      bus.resp_ready = 1'b1;
      bus.req_valid  = 2'b01;
      step();
      bus.req_valid = 2'b00;
      n_checks++; if (bus.alu_oe_out !== 1'b1) begin n_fail++; $display("FAIL midrst_issue: got oe %b want 1", bus.alu_oe_out); end
      rst_n = 1'b0;
      #1;
      n_checks++; if ({bus.alu_oe_out, bus.resp_valid} !== 2'b00) begin n_fail++; $display("FAIL midrst_clear: got oe/valid %b want 00", {bus.alu_oe_out, bus.resp_valid}); end
      step();
      rst_n = 1'b1;
      step();
      n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale: got valid %b want 0", bus.resp_valid); end
      bus.req0_cmd = 4'h3; bus.req0_a = 8'd255; bus.req0_b = 8'd0;
      bus.req_valid = 2'b01;
      #1;
      n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL midrst_ready: got %b want 01", bus.req_ready); end
      step();
      bus.req_valid = 2'b00;
      step();
      n_checks++; if ({bus.resp_valid, bus.resp_id, bus.resp_data} !== {1'b1, 1'b0, 16'd256}) begin n_fail++; $display("FAIL midrst_inc: got valid %b id %b data %0d want 1 0 256", bus.resp_valid, bus.resp_id, bus.resp_data); end
      step();
   endtask

   task automatic test_random();
      logic        busy, skip, winner, m_id, m_err, due;
      logic [3:0]  m_cmd;
      logic [7:0]  m_a, m_b;
      logic [15:0] m_data;
      logic [1:0]  exp_ready;
      logic        ptr;
      int          age;
      rst_n = 1'b0; bus.req_valid = 2'b00;
      step();
      rst_n = 1'b1;
      busy = 1'b0; skip = 1'b0; ptr = 1'b0; age = 0; winner = 1'b0;
      m_id = 1'b0; m_err = 1'b0; m_cmd = 4'h0; m_a = 8'h00; m_b = 8'h00; m_data = 16'h0000;
      for (int cyc = 0; cyc < 600; cyc++) begin
         bus.req_valid  = 2'($urandom_range(0, 3));
         bus.req0_cmd   = 4'($urandom); bus.req0_a = 8'($urandom);
         bus.req0_b     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         bus.req1_cmd   = 4'($urandom); bus.req1_a = 8'($urandom);
         bus.req1_b     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         bus.resp_ready = ($urandom_range(0, 3) != 0);
         #1;
         exp_ready = 2'b00;
         if (!busy && bus.req_valid != 2'b00) begin
            winner    = (bus.req_valid == 2'b11) ? ptr : bus.req_valid[1];
            exp_ready = winner ? 2'b10 : 2'b01;
         end
         due = busy && (age >= (skip ? 1 : 2));
         n_checks++; if (bus.req_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, bus.req_ready, exp_ready); end
         n_checks++; if (bus.alu_oe_out !== (busy && age == 1 && !skip)) begin n_fail++; $display("FAIL rand_oe@%0d: got %b want %b", cyc, bus.alu_oe_out, busy && age == 1 && !skip); end
         n_checks++; if (bus.resp_valid !== due) begin n_fail++; $display("FAIL rand_valid@%0d: got %b want %b", cyc, bus.resp_valid, due); end
         if (due) begin
            n_checks++; if ({bus.resp_id, bus.resp_err, bus.resp_data} !== {m_id, m_err, m_data}) begin n_fail++; $display("FAIL rand_resp@%0d: got id %b err %b data %h want %b %b %h", cyc, bus.resp_id, bus.resp_err, bus.resp_data, m_id, m_err, m_data); end
         end
         if (busy) begin
            n_checks++; if ({bus.alu_cmd_out, bus.alu_a_out, bus.alu_b_out} !== {m_cmd, m_a, m_b}) begin n_fail++; $display("FAIL rand_alu_pins@%0d: got %h want %h", cyc, {bus.alu_cmd_out, bus.alu_a_out, bus.alu_b_out}, {m_cmd, m_a, m_b}); end
         end
         if (exp_ready != 2'b00) begin
            busy  = 1'b1; age = 0; m_id = winner; ptr = ~winner;
            m_cmd = winner ? bus.req1_cmd : bus.req0_cmd;
            m_a   = winner ? bus.req1_a   : bus.req0_a;
            m_b   = winner ? bus.req1_b   : bus.req0_b;
`ifdef ALU_DIV0_CHECK_EN
            skip  = (m_cmd == 4'h5) && (m_b == 8'h00);
`else
            skip  = 1'b0;
`endif
            m_err  = skip;
            m_data = skip ? 16'h0000 : alu_f(m_cmd, m_a, m_b);
         end else if (due && bus.resp_ready) begin
            busy = 1'b0;
         end
         if (busy) age++;
         step();
      end
      bus.req_valid = 2'b00;
   endtask

   initial begin
      test_reset();
      test_contention();
      test_single_op();
      test_backpressure();
      test_div0();
      test_reset_mid_op();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
